des_expansion_pipe: RTL and testbench
=====================================

# des_expansion_pipe

Parametrised, pipelined successor to the DES E-expansion stage. Expands a 4·GROUPS-bit half-block into 6·GROUPS bits, using the DES E rule with wrap-around. Optionally XORs the result with a round subkey. Results move through a two-stage valid/ready pipeline with full backpressure and a wrapping completion counter. It sits between the right-half register and the S-box stage of the round datapath.

## Interface
Parameters:
- GROUPS, default 8: number of 4-bit input groups. Input width W = 4·GROUPS; output width X = 6·GROUPS. Legal range is 2..16.
- CNT_W, default 16: width of the completion counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  W  half-block. Index i is DES bit W+1−i, so in_data[W] is DES bit 1.
- in_key  input  X  subkey, sampled with in_data.
- in_key_en  input  1  1 = XOR the expansion with in_key; 0 = plain expansion. Sampled with in_data.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage 1 can accept a beat.
- out_data  output  X  expanded, optionally key-mixed result.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.
- blk_count  output  CNT_W  number of completed output handshakes since reset, modulo 2^CNT_W.

## Operation
Expansion rule, for group k = 0..GROUPS−1 counted from the MSB side:
- Output slice out[X−6k : X−6k−5] = { in[W−4k+1], in[W−4k : W−4k−3], in[W−4k−4] }.
- Wrap-around on the index: W+1 maps to 1, and 0 maps to W.
- For GROUPS=8 this is exactly the DES E table, e.g. out[48]=in[1], out[47:44]=in[32:29], out[43]=in[28], out[1]=in[32].

Stage 1 (s1):
- On an input handshake (in_valid & in_ready), register E(in_data), in_key and in_key_en, and set s1_valid.

Stage 2 (s2):
- On an s1→s2 advance, register s1_exp ^ (s1_key_en ? s1_key : 0) into out_data and set out_valid.
- out_data is driven directly from the s2 register; there is no combinational path from in_data.

Flow control:
- s2_free = !out_valid | out_ready.
- s1 advances when s1_valid & s2_free.
- in_ready = !s1_valid | s2_free. This is combinational from out_ready; there is no bubble, so full throughput is 1 beat/cycle.
- If s1 does not advance while s1 is full, s1 holds its contents and in_ready = 0.
- If s2 does not advance while s2 is full, s2 holds and out_data stays stable while out_valid = 1 and out_ready = 0.

Valid clearing:
- out_valid clears on an output handshake when no new beat advances from s1 in the same cycle.
- s1_valid clears on an advance when no new input handshake occurs in the same cycle.

Simultaneous events:
- An input handshake, an s1→s2 advance and an output handshake can all happen in one cycle. The pipeline shifts and both valids stay 1.

Counter:
- blk_count increments by 1 on every output handshake (out_valid & out_ready).
- It wraps from 2^CNT_W−1 to 0 with no saturation.

Data invariance:
- in_key and in_key_en are captured per beat. Changing them while no handshake occurs has no effect.
- When in_key_en = 0, the s1 key register contents are don't-care but must not affect out_data.

## Timing
Reset values (asynchronous, while rst = 1):
- s1_valid = 0, out_valid = 0.
- out_data = 0, blk_count = 0.
- in_ready = 1. It is combinational from the cleared valids, so it reads 1 during reset.

Reset mid-operation:
- Any beats in flight are discarded and are not counted.
- The first cycle after rst deasserts behaves as an empty pipeline.

Latency:
- An input handshake at edge n produces out_valid = 1 after edge n+1, provided there is no stall.
- Output is visible in the cycle after the second rising edge, i.e. latency 2.

Capacity:
- 2 beats. With out_ready held at 0, exactly two input handshakes complete, then in_ready = 0.
- in_ready returns to 1 in the same cycle that out_ready rises.

Ordering: no reordering, no drops, no duplication.

## Test plan
- Reset: assert rst mid-stream with 2 beats in flight, then release. Required: out_valid = 0, blk_count = 0, in_ready = 1, and no stale beat appears afterwards.
- Single-bit wrap, GROUPS=8, key_en=0:
  - in_data = 32'h00000001 gives out_data = 48'h800000000002.
  - in_data = 32'h80000000 gives 48'h400000000001.
  - In both cases out_valid asserts 2 cycles after the handshake.
- DES vector, GROUPS=8:
  - in_data = 32'hF0AAF0AA with key_en=0 gives 48'h7A15557A1555.
  - Same data with key_en=1 and in_key = 48'h1B02EFFC7072 gives 48'h6117BA866527.
  - Send both back to back; the outputs arrive in order on consecutive cycles.
- Backpressure: stream 6 beats with out_ready = 0 for 5 cycles, then 1. Required:
  - exactly 2 beats are accepted, then in_ready = 0;
  - out_data stays stable during the stall;
  - all 6 beats emerge in order;
  - blk_count = 6.
- Throughput and counter wrap: CNT_W=4, with in_valid and out_ready held at 1 for 20 beats. Required:
  - one beat completes per cycle;
  - blk_count reads 20 mod 16 = 4, having passed through 15 → 0.
- Parametrisation: with GROUPS=2 and in_data = 8'b1000_0001, out_data = 12'b110000_000011. Also run random checks against the software E model for GROUPS = 2, 8 and 16.

Source files
------------

// File: rtl/des_expansion_pipe.sv
// -----------------------------------------------------------------------------
// des_expansion_pipe
//
// Parametrised DES E-expansion with optional subkey mixing, carried through a
// two-stage valid/ready pipeline with full backpressure and a wrapping count
// of completed output beats.
//
// Stage 1 registers the expansion of the accepted half-block together with
// the per-beat key and key-enable. Stage 2 registers the key-mixed result,
// which drives out_data directly.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    4*GROUPS-bit half-block (MSB is DES bit 1)
//   in_key     6*GROUPS-bit subkey, captured with in_data
//   in_key_en  1 = XOR the expansion with in_key, captured with in_data
//   in_valid   input beat valid
//   in_ready   stage 1 can accept a beat (combinational from out_ready)
//   out_data   expanded, optionally key-mixed result (registered)
//   out_valid  out_data valid (registered)
//   out_ready  downstream accepts
//   blk_count  completed output handshakes since reset, wrapping
//
// GROUPS is meant to lie in 2..16; CNT_W sets the counter width.
// -----------------------------------------------------------------------------
module des_expansion_pipe #(
    parameter int GROUPS = 8,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*GROUPS-1:0]   in_data,
    input  logic [6*GROUPS-1:0]   in_key,
    input  logic                  in_key_en,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [6*GROUPS-1:0]   out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_W-1:0]      blk_count
);

    localparam int W = 4 * GROUPS;
    localparam int X = 6 * GROUPS;

    // Pipeline state
    logic [X-1:0]     s1_exp_q,    s1_exp_d;
    logic [X-1:0]     s1_key_q,    s1_key_d;
    logic             s1_key_en_q, s1_key_en_d;
    logic             s1_valid_q,  s1_valid_d;
    logic [X-1:0]     out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;

    // Combinational helpers
    logic [X-1:0] exp_s;
    logic [X-1:0] mix_s;
    logic         s2_free_s;
    logic         adv_s;
    logic         in_hs_s;
    logic         out_hs_s;

    // E rule per group: the 4 middle bits are copied straight through and the
    // two edge bits borrow the neighbouring groups' outer bits. The modulo on
    // the verilog index implements the DES wrap-around (bit W+1 -> 1, 0 -> W).
    for (genvar k = 0; k < GROUPS; k++) begin : g_exp
        localparam int HI = W - 4 * k - 1;   // verilog index of the group's MSB
        localparam int OB = X - 6 * k - 1;   // verilog index of the output MSB
        assign exp_s[OB]         = in_data[(HI + 1) % W];
        assign exp_s[OB-1 -: 4]  = in_data[HI -: 4];
        assign exp_s[OB-5]       = in_data[(HI + W - 4) % W];
    end

    // Flow control: stage 2 empties when downstream takes it, stage 1 may
    // move whenever stage 2 is (or is becoming) free, so no bubble is needed.
    always_comb begin
        s2_free_s = !out_valid_q || out_ready;
        adv_s     = s1_valid_q && s2_free_s;
        in_ready  = !s1_valid_q || s2_free_s;
        in_hs_s   = in_valid && in_ready;
        out_hs_s  = out_valid_q && out_ready;
        mix_s     = s1_exp_q ^ (s1_key_en_q ? s1_key_q : {X{1'b0}});
    end

    // Next-state for both stages and the completion counter
    always_comb begin
        s1_exp_d    = s1_exp_q;
        s1_key_d    = s1_key_q;
        s1_key_en_d = s1_key_en_q;
        s1_valid_d  = s1_valid_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;

        if (in_hs_s) begin
            s1_exp_d    = exp_s;
            s1_key_d    = in_key;
            s1_key_en_d = in_key_en;
            s1_valid_d  = 1'b1;
        end else if (adv_s) begin
            s1_valid_d  = 1'b0;
        end else begin
            s1_valid_d  = s1_valid_q;
        end

        if (adv_s) begin
            out_data_d  = mix_s;
            out_valid_d = 1'b1;
        end else if (out_hs_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (out_hs_s) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers, cleared asynchronously so in-flight beats are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_exp_q    <= {X{1'b0}};
            s1_key_q    <= {X{1'b0}};
            s1_key_en_q <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_data_q  <= {X{1'b0}};
            out_valid_q <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            s1_exp_q    <= s1_exp_d;
            s1_key_q    <= s1_key_d;
            s1_key_en_q <= s1_key_en_d;
            s1_valid_q  <= s1_valid_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign blk_count = cnt_q;

endmodule

// File: tb/tb_des_expansion_pipe.sv
// -----------------------------------------------------------------------------
// Bench for des_expansion_pipe. Three instances (GROUPS = 8 with a 4-bit
// counter, GROUPS = 2 and GROUPS = 16) share clock, reset and flow control,
// so they move in lockstep; each sees the low slice of a common stimulus.
// A software E model (DES bit numbering) plus a FIFO scoreboard supplies
// every expected output.
// -----------------------------------------------------------------------------
module tb_des_expansion_pipe;

    typedef struct {
        logic [63:0] d;
        logic [95:0] k;
        logic        en;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] tb_data = '0;
    logic [95:0] tb_key = '0;
    logic        tb_en = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy8, rdy2, rdy16;
    logic        ov8, ov2, ov16;
    logic [47:0] out8;
    logic [11:0] out2;
    logic [95:0] out16;
    logic [3:0]  cnt8;
    logic [15:0] cnt2, cnt16;

    int          checks = 0;
    int          failures = 0;
    beat_t       sb[$];
    logic [15:0] exp_cnt = '0;

    des_expansion_pipe #(.GROUPS(8), .CNT_W(4)) u8 (
        .clk(clk), .rst(rst), .in_data(tb_data[31:0]), .in_key(tb_key[47:0]),
        .in_key_en(tb_en), .in_valid(in_valid), .in_ready(rdy8),
        .out_data(out8), .out_valid(ov8), .out_ready(out_ready), .blk_count(cnt8));

    des_expansion_pipe #(.GROUPS(2), .CNT_W(16)) u2 (
        .clk(clk), .rst(rst), .in_data(tb_data[7:0]), .in_key(tb_key[11:0]),
        .in_key_en(tb_en), .in_valid(in_valid), .in_ready(rdy2),
        .out_data(out2), .out_valid(ov2), .out_ready(out_ready), .blk_count(cnt2));

    des_expansion_pipe #(.GROUPS(16), .CNT_W(16)) u16 (
        .clk(clk), .rst(rst), .in_data(tb_data), .in_key(tb_key),
        .in_key_en(tb_en), .in_valid(in_valid), .in_ready(rdy16),
        .out_data(out16), .out_valid(ov16), .out_ready(out_ready), .blk_count(cnt16));

    always #5 clk = ~clk;

    // DES E from the table's definition: output DES bit q (1-based) of group
    // k, position m takes input DES bit 4k+m-1 (1-based, wrapping mod W).
    // DES bit b lives at vector index W-b.
    function automatic logic [95:0] e_model(input int g, input logic [63:0] d);
        logic [95:0] r;
        int w;
        int x;
        r = '0;
        w = 4 * g;
        x = 6 * g;
        for (int q = 1; q <= x; q++) begin
            int k;
            int m;
            int src;
            k   = (q - 1) / 6;
            m   = (q - 1) % 6;
            src = ((4 * k + m - 1 + w) % w) + 1;
            r[x - q] = d[w - src];
        end
        return r;
    endfunction

    function automatic logic [95:0] expect_of(input int g, input beat_t b);
        logic [95:0] r;
        logic [95:0] msk;
        msk = '0;
        for (int i = 0; i < 6 * g; i++) msk[i] = 1'b1;
        r = e_model(g, b.d) ^ (b.en ? b.k : 96'h0);
        return r & msk;
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 96'(ov8), 96'h0);
        chk("rst_blk_count", 96'(cnt8), 96'h0);
        chk("rst_in_ready", 96'(rdy8), 96'h1);
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Scoreboard monitor; handshakes are judged at the falling edge, where
    // every input and combinational output is settled for the coming edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_cnt = '0;
        end else begin
            chk("cnt8", 96'(cnt8), 96'(exp_cnt[3:0]));
            chk("cnt16", 96'(cnt16), 96'(exp_cnt));
            if (ov8 && out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_beat", 96'(ov8), 96'h0);
                end else begin
                    beat_t b;
                    b = sb.pop_front();
                    chk("data_g8", 96'(out8), expect_of(8, b));
                    chk("data_g2", 96'(out2), expect_of(2, b));
                    chk("data_g16", out16, expect_of(16, b));
                    chk("valid_g2", 96'(ov2), 96'h1);
                    chk("valid_g16", 96'(ov16), 96'h1);
                end
                exp_cnt = exp_cnt + 16'd1;
            end
            if (in_valid && rdy8) begin
                beat_t nb;
                nb.d  = tb_data;
                nb.k  = tb_key;
                nb.en = tb_en;
                sb.push_back(nb);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        logic [47:0] held;
        logic [63:0] bp_data[6];

        held = '0;
        reset_dut();

        // Single-bit wrap cases with latency check
        out_ready = 1'b1;
        tb_en = 1'b0;
        tb_data = 64'h1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat1_early", 96'(ov8), 96'h0);
        tick();
        @(negedge clk);
        chk("lat1_valid", 96'(ov8), 96'h1);
        chk("wrap_lsb", 96'(out8), 96'h800000000002);
        tick();

        tb_data = 64'h80000000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("lat2_early", 96'(ov8), 96'h0);
        tick();
        @(negedge clk);
        chk("lat2_valid", 96'(ov8), 96'h1);
        chk("wrap_msb", 96'(out8), 96'h400000000001);
        tick();

        // GROUPS = 2 directed vector
        tb_data = 64'h81;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("g2_vector", 96'(out2), 96'hC03);
        tick();

        // DES vector back to back, plain then keyed
        tb_data = 64'hF0AAF0AA;
        tb_key = 96'h1B02EFFC7072;
        tb_en = 1'b0;
        in_valid = 1'b1;
        tick();
        tb_en = 1'b1;
        tick();
        in_valid = 1'b0;
        tb_en = 1'b0;
        tb_key = 96'hFFFF_FFFF_FFFF;
        @(negedge clk);
        chk("des_plain_valid", 96'(ov8), 96'h1);
        chk("des_plain", 96'(out8), 96'h7A15557A1555);
        tick();
        @(negedge clk);
        chk("des_keyed_valid", 96'(ov8), 96'h1);
        chk("des_keyed", 96'(out8), 96'h6117BA866527);
        tick();
        tick();

        // Reset with two beats in flight
        out_ready = 1'b0;
        in_valid = 1'b1;
        tb_data = 64'h1234_5678_9ABC_DEF0;
        tick();
        tb_data = 64'h0FED_CBA9_8765_4321;
        tick();
        in_valid = 1'b0;
        chk("inflight_full", 96'(rdy8), 96'h0);
        reset_dut();
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_stale", 96'(ov8), 96'h0);
            tick();
        end
        chk("post_rst_cnt", 96'(cnt8), 96'h0);

        // Backpressure: 6 beats, out_ready low for 5 cycles
        reset_dut();
        for (int i = 0; i < 6; i++) bp_data[i] = {$urandom(), $urandom()};
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            tb_data = bp_data[acc];
            tb_key = {$urandom(), $urandom(), $urandom()};
            tb_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rdy8) acc++;
            if (c == 2) held = out8;
            if (c > 2) chk("bp_stable", 96'(out8), 96'(held));
            tick();
        end
        chk("bp_accepted", 96'(acc), 96'h2);
        chk("bp_ready_low", 96'(rdy8), 96'h0);
        out_ready = 1'b1;
        #1;
        chk("bp_ready_rise", 96'(rdy8), 96'h1);
        for (int c = 0; c < 30 && acc < 6; c++) begin
            in_valid = 1'b1;
            tb_data = bp_data[acc];
            tb_key = {$urandom(), $urandom(), $urandom()};
            tb_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (rdy8) acc++;
            tick();
        end
        in_valid = 1'b0;
        chk("bp_all_in", 96'(acc), 96'h6);
        repeat (4) tick();
        chk("bp_count8", 96'(cnt8), 96'h6);
        chk("bp_count2", 96'(cnt2), 96'h6);
        chk("bp_drained", 96'(sb.size()), 96'h0);

        // Full throughput and counter wrap (4-bit counter on the GROUPS=8 unit)
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            tb_data = {$urandom(), $urandom()};
            tb_key = {$urandom(), $urandom(), $urandom()};
            tb_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("tp_ready", 96'(rdy8), 96'h1);
            if (i >= 2) chk("tp_valid", 96'(ov8), 96'h1);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("tp_wrap_cnt8", 96'(cnt8), 96'h4);
        chk("tp_cnt16", 96'(cnt16), 96'd20);

        // Random traffic with random backpressure, all three widths
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 3) != 0);
            tb_data = {$urandom(), $urandom()};
            tb_key = {$urandom(), $urandom(), $urandom()};
            tb_en = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (6) tick();
        chk("rand_drained", 96'(sb.size()), 96'h0);
        chk("rand_out_idle", 96'(ov8), 96'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
